// File: rtl/atu_pkg.sv
// Shared angle geometry, angle types and move-controller states for the ATU move sequencer.
package atu_pkg;
    localparam int ANGLE_W    = 12;
    localparam int ANGLE_STEP = 4;
    localparam int ANGLE_MAX  = 4020;
    localparam int ANGLE_MOD  = ANGLE_MAX + ANGLE_STEP;

    typedef logic [ANGLE_W-1:0] angle_t;
    typedef logic [ANGLE_W:0]   delta_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAN,
        ST_MOVE,
        ST_SETTLE,
        ST_FAULT
    } atu_move_state_t;

    function automatic logic target_legal(input angle_t t);
        return (int'(t) <= ANGLE_MAX) && ((int'(t) % ANGLE_STEP) == 0);
    endfunction

    // Clockwise distance from cur to target, wrapped into [0, ANGLE_MOD).
    function automatic delta_t delta_cw(input angle_t target, input angle_t cur);
        delta_t t;
        delta_t c;
        t = {1'b0, target};
        c = {1'b0, cur};
        if (target >= cur) begin
            return t - c;
        end
        return t + delta_t'(ANGLE_MOD) - c;
    endfunction

    function automatic logic shortest_cw(input delta_t d);
        return d <= delta_t'(ANGLE_MOD / 2);
    endfunction
endpackage

// File: rtl/atu_stall_watchdog.sv
// Counts consecutive enabled cycles without a clear; pulses timeout on the STALL_CYCLES-th one.
module atu_stall_watchdog #(
    parameter int unsigned STALL_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic timeout
);
    localparam int CNT_W = $clog2(STALL_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d   = '0;
        timeout = 1'b0;
        if (enable && !clear) begin
            if (cnt_q == CNT_W'(STALL_CYCLES - 1)) begin
                timeout = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/atu_move_controller.sv
// Sequences motor and ATU for commanded moves: plan, move, settle, done, with stall/retry fault.
// Build option ATU_MOVE_SHORTEST_EN: initial direction is the shortest path instead of cmd_cw.
module atu_move_controller
    import atu_pkg::*;
#(
    parameter int unsigned STALL_CYCLES  = 1000000,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ANGLE_W-1:0] cmd_target,
    input  logic               cmd_cw,
    input  logic               abort,
    input  logic               fault_clr,
    input  logic [ANGLE_W-1:0] angle,
    output logic               motor_en,
    output logic               motor_cw,
    output logic               atu_monitor,
    output logic               busy,
    output logic               done,
    output logic               cmd_err,
    output logic               fault
);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int RETRY_W  = $clog2(MAX_RETRY + 2);

    atu_move_state_t   state_q, state_d;
    angle_t            target_q, target_d;
    logic              cw_req_q, cw_req_d;
    logic              motor_cw_q, motor_cw_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic              done_q, done_d;
    logic              cmd_err_q, cmd_err_d;
    angle_t            angle_prev_q;
    logic              stall_timeout;
    delta_t            delta;

    atu_stall_watchdog #(
        .STALL_CYCLES(STALL_CYCLES)
    ) u_watchdog (
        .clk    (CLK),
        .rst_n  (reset),
        .enable (state_q == ST_MOVE),
        .clear  (angle != angle_prev_q),
        .timeout(stall_timeout)
    );

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        cw_req_d   = cw_req_q;
        motor_cw_d = motor_cw_q;
        retry_d    = retry_q;
        settle_d   = settle_q;
        done_d     = 1'b0;
        cmd_err_d  = 1'b0;
        delta      = delta_cw(target_q, angle);

        case (state_q)
            ST_IDLE: begin
                retry_d  = '0;
                settle_d = '0;
                if (cmd_valid) begin
                    target_d = cmd_target;
                    cw_req_d = cmd_cw;
                    if (!target_legal(cmd_target)) begin
                        cmd_err_d = 1'b1;
                    end else if (cmd_target == angle) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_PLAN;
                    end
                end
            end
            ST_PLAN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
`ifdef ATU_MOVE_SHORTEST_EN
                    motor_cw_d = shortest_cw(delta);
`else
                    // Only the first leg honours the requested direction; corrections take the short way back.
                    motor_cw_d = (retry_q == '0) ? cw_req_q : shortest_cw(delta);
`endif
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                settle_d = '0;
                if (stall_timeout) begin
                    state_d = ST_FAULT;
                end else if (abort) begin
                    state_d = ST_IDLE;
                end else if (angle == target_q) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (angle != target_q) begin
                    settle_d = '0;
                    retry_d  = retry_q + 1'b1;
                    state_d  = (retry_q < RETRY_W'(MAX_RETRY)) ? ST_PLAN : ST_FAULT;
                end else if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    done_d   = 1'b1;
                    retry_d  = '0;
                    settle_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    retry_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            target_q     <= '0;
            cw_req_q     <= 1'b1;
            motor_cw_q   <= 1'b1;
            retry_q      <= '0;
            settle_q     <= '0;
            done_q       <= 1'b0;
            cmd_err_q    <= 1'b0;
            angle_prev_q <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            cw_req_q     <= cw_req_d;
            motor_cw_q   <= motor_cw_d;
            retry_q      <= retry_d;
            settle_q     <= settle_d;
            done_q       <= done_d;
            cmd_err_q    <= cmd_err_d;
            angle_prev_q <= angle;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign motor_en    = (state_q == ST_MOVE);
    assign motor_cw    = motor_cw_q;
    assign atu_monitor = (state_q == ST_MOVE) || (state_q == ST_SETTLE);
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_FAULT);
    assign done        = done_q;
    assign cmd_err     = cmd_err_q;
    assign fault       = (state_q == ST_FAULT);
endmodule

// File: tb/tb_atu_move_controller.sv
// Self-checking bench for atu_move_controller: a simple motor model turns the angle while motor_en is high.
module tb_atu_move_controller;
    localparam int STALL = 200;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd_target = '0;
    logic        cmd_cw = 1'b1;
    logic        abort = 1'b0;
    logic        fault_clr = 1'b0;
    logic [11:0] angle = '0;
    logic        motor_en, motor_cw, atu_monitor, busy, done, cmd_err, fault;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    bit auto_motor = 1'b1;

    always #5 CLK = ~CLK;

    atu_move_controller #(
        .STALL_CYCLES (STALL),
        .SETTLE_CYCLES(16),
        .MAX_RETRY    (3)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_cw     (cmd_cw),
        .abort      (abort),
        .fault_clr  (fault_clr),
        .angle      (angle),
        .motor_en   (motor_en),
        .motor_cw   (motor_cw),
        .atu_monitor(atu_monitor),
        .busy       (busy),
        .done       (done),
        .cmd_err    (cmd_err),
        .fault      (fault)
    );

    // One clock; the motor model advances the angle by one hall step per cycle of enable.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (auto_motor && motor_en) begin
            if (motor_cw) angle = (angle >= 12'd4020) ? 12'd0 : angle + 12'd4;
            else          angle = (angle == 12'd0) ? 12'd4020 : angle - 12'd4;
        end
    endtask

    task automatic issue(input logic [11:0] t, input logic cw);
        cmd_target = t;
        cmd_cw     = cw;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
    endtask

    // Returns 1 for done, 2 for cmd_err (3 both), 0 if nothing within limit cycles.
    task automatic wait_pulse(input int limit, output int kind, output int cycles);
        kind = 0;
        cycles = 0;
        while (kind == 0 && cycles < limit) begin
            tick();
            cycles++;
            kind = (done ? 1 : 0) | (cmd_err ? 2 : 0);
        end
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        #23;
        outs = {cmd_ready, motor_en, motor_cw, atu_monitor, busy, done, cmd_err, fault};
        vectors++;
        if (outs !== 8'b1010_0000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 10100000", outs);
        end
        @(negedge CLK);
        reset = 1'b1;
        tick();
        angle = 12'd0;
        auto_motor = 1'b1;
        issue(12'd400, 1'b1);
        tick();
        vectors++;
        if (motor_en !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pre_move: motor_en=%b expected 1", motor_en);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({motor_en, cmd_ready, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL reset_mid_move: en/ready/busy=%b expected 010", {motor_en, cmd_ready, busy});
        end
        @(negedge CLK);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_move_cw();
        int n, kind, cyc, exp;
        angle = 12'd0;
        exp_q.push_back(1);
        issue(12'd400, 1'b1);
        vectors++;
        if ({motor_en, cmd_ready, busy} !== 3'b001) begin
            miscompares++;
            $display("FAIL plan_state: en/ready/busy=%b expected 001", {motor_en, cmd_ready, busy});
        end
        cmd_target = 12'd0;
        cmd_valid  = 1'b1;
        tick();
        vectors++;
        if ({motor_en, motor_cw, atu_monitor, cmd_ready} !== 4'b1110) begin
            miscompares++;
            $display("FAIL move_start: en/cw/mon/ready=%b expected 1110",
                     {motor_en, motor_cw, atu_monitor, cmd_ready});
        end
        n = 0;
        while (motor_en && n < 1100) begin
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        vectors++;
        if (n !== 100 || angle !== 12'd400) begin
            miscompares++;
            $display("FAIL move_arrive: cycles=%0d angle=%0d expected 100/400", n, angle);
        end
        vectors++;
        if (atu_monitor !== 1'b1) begin
            miscompares++;
            $display("FAIL settle_monitor: atu_monitor=%b expected 1", atu_monitor);
        end
        wait_pulse(40, kind, cyc);
        exp = (exp_q.size() == 0) ? 0 : exp_q.pop_front();
        vectors++;
        if (kind !== exp || cyc !== 16) begin
            miscompares++;
            $display("FAIL move_done: kind=%0d after %0d expected kind %0d after 16", kind, cyc, exp);
        end
    endtask

    task automatic test_wrap();
        int n, kind, cyc, exp, extra;
        bit saw_wrap;
        angle = 12'd8;
        exp_q.push_back(1);
        issue(12'd4012, 1'b0);
        tick();
        vectors++;
        if ({motor_en, motor_cw} !== 2'b10) begin
            miscompares++;
            $display("FAIL wrap_start: en/cw=%b expected 10", {motor_en, motor_cw});
        end
        n = 0;
        saw_wrap = 1'b0;
        while (motor_en && n < 1100) begin
            tick();
            n++;
            if (angle == 12'd4020) saw_wrap = 1'b1;
        end
        vectors++;
        if (n !== 5 || angle !== 12'd4012 || saw_wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_arrive: cycles=%0d angle=%0d wrap=%b expected 5/4012/1", n, angle, saw_wrap);
        end
        wait_pulse(40, kind, cyc);
        exp = (exp_q.size() == 0) ? 0 : exp_q.pop_front();
        vectors++;
        if (kind !== exp || cyc !== 16) begin
            miscompares++;
            $display("FAIL wrap_done: kind=%0d after %0d expected kind %0d after 16", kind, cyc, exp);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL wrap_single_done: extra pulses=%0d expected 0", extra);
        end
    endtask

    task automatic test_cmd_err();
        int kind, exp;
        logic [11:0] bad [2];
        bad[0] = 12'd401;
        bad[1] = 12'd4024;
        angle = 12'd800;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(2);
            issue(bad[i], 1'b1);
            kind = (done ? 1 : 0) | (cmd_err ? 2 : 0);
            exp = (exp_q.size() == 0) ? 0 : exp_q.pop_front();
            vectors++;
            if (kind !== exp) begin
                miscompares++;
                $display("FAIL illegal_%0d: pulse kind=%0d expected %0d", bad[i], kind, exp);
            end
            tick();
            vectors++;
            if ({cmd_err, motor_en, cmd_ready} !== 3'b001) begin
                miscompares++;
                $display("FAIL illegal_after_%0d: err/en/ready=%b expected 001", bad[i], {cmd_err, motor_en, cmd_ready});
            end
        end
        exp_q.push_back(1);
        issue(12'd800, 1'b1);
        kind = (done ? 1 : 0) | (cmd_err ? 2 : 0);
        exp = (exp_q.size() == 0) ? 0 : exp_q.pop_front();
        vectors++;
        if (kind !== exp) begin
            miscompares++;
            $display("FAIL at_target: pulse kind=%0d expected %0d", kind, exp);
        end
        tick();
        vectors++;
        if ({done, motor_en, cmd_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL at_target_after: done/en/ready=%b expected 001", {done, motor_en, cmd_ready});
        end
    endtask

    task automatic test_stall();
        int n;
        auto_motor = 1'b0;
        angle = 12'd0;
        issue(12'd400, 1'b1);
        tick();
        n = 0;
        while (!fault && n < 400) begin
            tick();
            n++;
        end
        vectors++;
        if (n !== STALL || {fault, motor_en, cmd_ready, busy} !== 4'b1000) begin
            miscompares++;
            $display("FAIL stall_fault: cycles=%0d f/en/ready/busy=%b expected %0d/1000",
                     n, {fault, motor_en, cmd_ready, busy}, STALL);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (fault !== 1'b1) begin
            miscompares++;
            $display("FAIL fault_abort_ignored: fault=%b expected 1", fault);
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        vectors++;
        if ({fault, cmd_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL fault_clear: fault/ready=%b expected 01", {fault, cmd_ready});
        end
        auto_motor = 1'b1;
    endtask

    task automatic test_retry_abort();
        int n, pulses;
        angle = 12'd0;
        issue(12'd400, 1'b1);
        tick();
        n = 0;
        while (motor_en && n < 1100) begin
            tick();
            n++;
        end
        pulses = 0;
        for (int o = 1; o <= 4; o++) begin
            angle = 12'd404;
            tick();
            if (o < 4) begin
                tick();
                vectors++;
                if ({motor_en, motor_cw} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL retry_%0d_dir: en/cw=%b expected 10", o, {motor_en, motor_cw});
                end
                tick();
                if (done) pulses++;
            end
        end
        vectors++;
        if ({fault, motor_en} !== 2'b10 || pulses !== 0) begin
            miscompares++;
            $display("FAIL retry_exhaust: fault/en=%b dones=%0d expected 10/0", {fault, motor_en}, pulses);
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        angle = 12'd0;
        issue(12'd400, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if ({motor_en, cmd_ready, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL abort_move: en/ready/busy=%b expected 010", {motor_en, cmd_ready, busy});
        end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: dones=%0d expected 0", pulses);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        test_reset();
        test_move_cw();
        test_wrap();
        test_cmd_err();
        test_stall();
        test_retry_abort();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d events left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
